// File: rtl/filter_multicast_receiver_pkg.sv
// Shared NoC definitions: receiver FSM states and the broadcast column tag.
package filter_multicast_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } rx_state_e;

    // Widest tag supported; narrower users slice the low bits.
    localparam int unsigned TAG_WIDTH_MAX = 32;
    localparam logic [TAG_WIDTH_MAX-1:0] COL_BCAST_ALL = '1;

endpackage

// File: rtl/filter_multicast_receiver_if.sv
// Configuration, tagged input bus and scratchpad output bus of the multicast receiver.
interface filter_multicast_receiver_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4,
    parameter int CNT_WIDTH     = 8
);
    logic                     cfg_load;
    logic [ROW_TAG_WIDTH-1:0] cfg_row_id;
    logic [COL_TAG_WIDTH-1:0] cfg_col_id;
    logic [CNT_WIDTH-1:0]     cfg_count;

    logic                     in_valid;
    logic [ROW_TAG_WIDTH-1:0] in_row_tag;
    logic [COL_TAG_WIDTH-1:0] in_col_tag;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     in_ready;

    logic                     out_valid;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_ready;

    logic                     busy;
    logic                     done;

    modport master (
        output cfg_load, cfg_row_id, cfg_col_id, cfg_count,
        output in_valid, in_row_tag, in_col_tag, in_data,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready,
        input  busy, done
    );

    modport slave (
        input  cfg_load, cfg_row_id, cfg_col_id, cfg_count,
        input  in_valid, in_row_tag, in_col_tag, in_data,
        output in_ready,
        output out_valid, out_data,
        input  out_ready,
        output busy, done
    );
endinterface

// File: rtl/filter_multicast_receiver_tag_matcher.sv
// Combinational row/column tag comparison; an all-ones column tag reaches every column.
module tag_matcher
    import filter_multicast_receiver_pkg::*;
#(
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4
) (
    input  logic [ROW_TAG_WIDTH-1:0] row_id_i,
    input  logic [COL_TAG_WIDTH-1:0] col_id_i,
    input  logic [ROW_TAG_WIDTH-1:0] row_tag_i,
    input  logic [COL_TAG_WIDTH-1:0] col_tag_i,
    output logic                     match_o
);
    localparam logic [COL_TAG_WIDTH-1:0] COL_BCAST = COL_BCAST_ALL[COL_TAG_WIDTH-1:0];

    assign match_o = (row_tag_i == row_id_i) &&
                     ((col_tag_i == col_id_i) || (col_tag_i == COL_BCAST));
endmodule

// File: rtl/filter_multicast_receiver.sv
// Multicast filter receiver: accepts matching tagged words into a one-entry hold
// register for the PE scratchpad, drops the rest, and signals pass completion.
module filter_multicast_receiver
    import filter_multicast_receiver_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    filter_multicast_receiver_if.slave      bus
);
    rx_state_e                state_q, state_d;
    logic [ROW_TAG_WIDTH-1:0] row_id_q, row_id_d;
    logic [COL_TAG_WIDTH-1:0] col_id_q, col_id_d;
    logic [CNT_WIDTH-1:0]     count_q, count_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic                     hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0]    hold_data_q, hold_data_d;

    logic tag_match;
    logic cnt_full;
    logic in_ready;
    logic match_xfer;
    logic drain;

    tag_matcher #(
        .ROW_TAG_WIDTH (ROW_TAG_WIDTH),
        .COL_TAG_WIDTH (COL_TAG_WIDTH)
    ) u_tag_matcher (
        .row_id_i  (row_id_q),
        .col_id_i  (col_id_q),
        .row_tag_i (bus.in_row_tag),
        .col_tag_i (bus.in_col_tag),
        .match_o   (tag_match)
    );

    // Non-matching words always flow; matching words need room and an unfinished quota.
    assign cnt_full   = (cnt_q == count_q);
    assign in_ready   = (state_q == ACTIVE) &&
                        (!tag_match || (!cnt_full && (!hold_valid_q || bus.out_ready)));
    assign match_xfer = bus.in_valid && in_ready && tag_match;
    assign drain      = hold_valid_q && bus.out_ready;

    always_comb begin
        state_d      = state_q;
        row_id_d     = row_id_q;
        col_id_d     = col_id_q;
        count_d      = count_q;
        cnt_d        = cnt_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;

        if (match_xfer) begin
            hold_valid_d = 1'b1;
            hold_data_d  = bus.in_data;
            cnt_d        = cnt_q + CNT_WIDTH'(1);
        end else if (drain) begin
            hold_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.cfg_load) begin
                    row_id_d = bus.cfg_row_id;
                    col_id_d = bus.cfg_col_id;
                    count_d  = bus.cfg_count;
                    cnt_d    = '0;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                // Finish once the quota is met and the last word leaves this edge.
                if (cnt_full && !hold_valid_d) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            row_id_q     <= '0;
            col_id_q     <= '0;
            count_q      <= '0;
            cnt_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            row_id_q     <= row_id_d;
            col_id_q     <= col_id_d;
            count_q      <= count_d;
            cnt_q        <= cnt_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = hold_valid_q;
    assign bus.out_data  = hold_data_q;
    assign bus.busy      = (state_q == ACTIVE);
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_filter_multicast_receiver.sv
// Directed bench for filter_multicast_receiver: per-cycle vector table plus a streaming pass.
module tb_filter_multicast_receiver;

    logic clk;
    logic reset;

    filter_multicast_receiver_if #(
        .DATA_WIDTH    (64),
        .ROW_TAG_WIDTH (4),
        .COL_TAG_WIDTH (4),
        .CNT_WIDTH     (8)
    ) bus ();

    filter_multicast_receiver #(
        .DATA_WIDTH    (64),
        .ROW_TAG_WIDTH (4),
        .COL_TAG_WIDTH (4),
        .CNT_WIDTH     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [3:0]  cr;
        logic [3:0]  cc;
        logic [7:0]  cn;
        logic        v;
        logic [3:0]  rt;
        logic [3:0]  ct;
        logic [63:0] d;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [63:0] e_od;
        logic        od_care;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(
        input logic rst, input logic ld, input logic [3:0] cr, input logic [3:0] cc,
        input logic [7:0] cn, input logic v, input logic [3:0] rt, input logic [3:0] ct,
        input logic [63:0] d, input logic ordy, input logic e_rdy, input logic e_ov,
        input logic [63:0] e_od, input logic od_care, input logic e_busy, input logic e_done);
        vec_t t;
        t.rst = rst; t.ld = ld; t.cr = cr; t.cc = cc; t.cn = cn;
        t.v = v; t.rt = rt; t.ct = ct; t.d = d; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_od = e_od; t.od_care = od_care;
        t.e_busy = e_busy; t.e_done = e_done;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        reset          = t.rst;
        bus.cfg_load   = t.ld;
        bus.cfg_row_id = t.cr;
        bus.cfg_col_id = t.cc;
        bus.cfg_count  = t.cn;
        bus.in_valid   = t.v;
        bus.in_row_tag = t.rt;
        bus.in_col_tag = t.ct;
        bus.in_data    = t.d;
        bus.out_ready  = t.ordy;
    endtask

    localparam logic [63:0] A1 = 64'hDEAD_BEEF_0000_00A1;
    localparam logic [63:0] A2 = 64'hDEAD_BEEF_0000_00A2;
    localparam logic [63:0] B0 = 64'h0BAD_0BAD_0BAD_0BAD;
    localparam logic [63:0] C1 = 64'hC1C1_0000_1111_0001;
    localparam logic [63:0] C2 = 64'hC2C2_0000_2222_0002;
    localparam logic [63:0] C3 = 64'hC3C3_0000_3333_0003;
    localparam logic [63:0] C4 = 64'hC4C4_0000_4444_0004;
    localparam logic [63:0] E2 = 64'hE2E2_E2E2_0000_0000;
    localparam logic [63:0] G1 = 64'hFFFF_0000_FFFF_0001;
    localparam logic [63:0] G3 = 64'h1234_5678_9ABC_DEF0;

    initial begin
        logic [63:0] prev;
        bit          seen;

        //          rst ld cr cc cn   v rt ct  d         ordy | rdy ov od  care busy done
        vecs.push_back(mk(1,0,0,0,0,  0,0,0,64'h0,    0,   0,0,64'h0,1,0,0)); // 0 reset
        vecs.push_back(mk(0,1,2,3,2,  0,0,0,64'h0,    0,   0,0,64'h0,0,0,0)); // 1 cfg (2,3) x2
        vecs.push_back(mk(0,0,0,0,0,  1,2,3,A1,       1,   1,0,64'h0,0,1,0)); // 2
        vecs.push_back(mk(0,0,0,0,0,  1,1,3,B0,       1,   1,1,A1,   1,1,0)); // 3 drop (1,3)
        vecs.push_back(mk(0,0,0,0,0,  1,2,3,A2,       1,   1,0,64'h0,0,1,0)); // 4
        vecs.push_back(mk(0,0,0,0,0,  0,0,0,64'h0,    1,   1,1,A2,   1,1,0)); // 5
        vecs.push_back(mk(0,0,0,0,0,  0,0,0,64'h0,    1,   0,0,64'h0,0,0,1)); // 6 done
        vecs.push_back(mk(0,0,0,0,0,  0,0,0,64'h0,    0,   0,0,64'h0,0,0,0)); // 7 idle
        vecs.push_back(mk(0,1,5,1,3,  0,0,0,64'h0,    0,   0,0,64'h0,0,0,0)); // 8 cfg (5,1) x3
        vecs.push_back(mk(0,0,0,0,0,  1,5,1,C1,       0,   1,0,64'h0,0,1,0)); // 9
        vecs.push_back(mk(0,0,0,0,0,  1,5,1,C2,       0,   0,1,C1,   1,1,0)); // 10 stall
        vecs.push_back(mk(0,0,0,0,0,  1,4,1,B0,       0,   1,1,C1,   1,1,0)); // 11 drop while full
        vecs.push_back(mk(0,0,0,0,0,  1,5,1,C2,       1,   1,1,C1,   1,1,0)); // 12 drain+fill
        vecs.push_back(mk(0,0,0,0,0,  1,5,15,C3,      1,   1,1,C2,   1,1,0)); // 13 broadcast
        vecs.push_back(mk(0,0,0,0,0,  1,5,1,C4,       0,   0,1,C3,   1,1,0)); // 14 quota met
        vecs.push_back(mk(0,0,0,0,0,  1,5,1,C4,       1,   0,1,C3,   1,1,0)); // 15
        vecs.push_back(mk(0,1,7,7,1,  1,2,2,B0,       1,   0,0,64'h0,0,0,1)); // 16 done, cfg ignored
        vecs.push_back(mk(0,0,0,0,0,  0,0,0,64'h0,    0,   0,0,64'h0,0,0,0)); // 17 idle
        vecs.push_back(mk(0,1,6,2,1,  0,0,0,64'h0,    0,   0,0,64'h0,0,0,0)); // 18 cfg (6,2) x1
        vecs.push_back(mk(0,1,7,15,5, 1,7,15,B0,      1,   1,0,64'h0,0,1,0)); // 19 bcast row miss, cfg ignored
        vecs.push_back(mk(0,0,0,0,0,  1,6,2,E2,       0,   1,0,64'h0,0,1,0)); // 20
        vecs.push_back(mk(0,0,0,0,0,  1,6,2,B0,       1,   0,1,E2,   1,1,0)); // 21
        vecs.push_back(mk(0,0,0,0,0,  0,0,0,64'h0,    0,   0,0,64'h0,0,0,1)); // 22
        vecs.push_back(mk(0,0,0,0,0,  0,0,0,64'h0,    0,   0,0,64'h0,0,0,0)); // 23
        vecs.push_back(mk(0,1,1,1,0,  0,0,0,64'h0,    0,   0,0,64'h0,0,0,0)); // 24 cfg count 0
        vecs.push_back(mk(0,0,0,0,0,  1,1,1,B0,       1,   0,0,64'h0,0,1,0)); // 25
        vecs.push_back(mk(0,0,0,0,0,  1,1,1,B0,       1,   0,0,64'h0,0,0,1)); // 26
        vecs.push_back(mk(0,0,0,0,0,  0,0,0,64'h0,    0,   0,0,64'h0,0,0,0)); // 27
        vecs.push_back(mk(0,1,3,3,4,  0,0,0,64'h0,    0,   0,0,64'h0,0,0,0)); // 28 cfg (3,3) x4
        vecs.push_back(mk(0,0,0,0,0,  1,3,3,G1,       0,   1,0,64'h0,0,1,0)); // 29
        vecs.push_back(mk(1,0,0,0,0,  0,0,0,64'h0,    0,   1,1,G1,   1,1,0)); // 30 reset mid-pass
        vecs.push_back(mk(0,0,0,0,0,  1,3,3,B0,       0,   0,0,64'h0,1,0,0)); // 31
        vecs.push_back(mk(0,1,3,3,1,  0,0,0,64'h0,    0,   0,0,64'h0,0,0,0)); // 32 new cfg x1
        vecs.push_back(mk(0,0,0,0,0,  1,3,3,G3,       1,   1,0,64'h0,0,1,0)); // 33
        vecs.push_back(mk(0,0,0,0,0,  0,0,0,64'h0,    1,   1,1,G3,   1,1,0)); // 34
        vecs.push_back(mk(0,0,0,0,0,  0,0,0,64'h0,    0,   0,0,64'h0,0,0,1)); // 35
        vecs.push_back(mk(0,0,0,0,0,  0,0,0,64'h0,    0,   0,0,64'h0,0,0,0)); // 36

        drive(mk(1,0,0,0,0,0,0,0,64'h0,0,0,0,64'h0,0,0,0));
        repeat (2) @(negedge clk);

        // Inputs change on posedge; outputs sampled mid-phase, state moves on negedge.
        foreach (vecs[i]) begin
            @(posedge clk);
            drive(vecs[i]);
            #2;
            chk($sformatf("v%0d.in_ready", i), 64'(bus.in_ready), 64'(vecs[i].e_rdy));
            chk($sformatf("v%0d.out_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_ov));
            if (vecs[i].od_care)
                chk($sformatf("v%0d.out_data", i), bus.out_data, vecs[i].e_od);
            chk($sformatf("v%0d.busy", i), 64'(bus.busy), 64'(vecs[i].e_busy));
            chk($sformatf("v%0d.done", i), 64'(bus.done), 64'(vecs[i].e_done));
        end

        // Back-to-back matching stream with the consumer always ready.
        @(posedge clk);
        drive(mk(0,1,9,0,4,0,0,0,64'h0,1,0,0,64'h0,0,0,0));
        prev = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            drive(mk(0,0,0,0,0,1,9,0,64'h5000 + 64'(k),1,0,0,64'h0,0,0,0));
            #2;
            chk($sformatf("stream%0d.in_ready", k), 64'(bus.in_ready), 64'h1);
            chk($sformatf("stream%0d.out_valid", k), 64'(bus.out_valid), (k == 0) ? 64'h0 : 64'h1);
            if (k > 0)
                chk($sformatf("stream%0d.out_data", k), bus.out_data, prev);
            prev = 64'h5000 + 64'(k);
        end
        @(posedge clk);
        drive(mk(0,0,0,0,0,0,0,0,64'h0,1,0,0,64'h0,0,0,0));
        #2;
        chk("stream.last_valid", 64'(bus.out_valid), 64'h1);
        chk("stream.last_data", bus.out_data, prev);
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(posedge clk);
            #2;
            if (bus.done) seen = 1'b1;
        end
        chk("stream.done_seen", 64'(seen), 64'h1);
        @(posedge clk);
        #2;
        chk("stream.idle_busy", 64'(bus.busy), 64'h0);
        chk("stream.idle_valid", 64'(bus.out_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
